// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory responder.
// Fixed response latency, byte-lane stores, fault on bad address.
module mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_commit;
    logic        w_op_write;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic [3:0]  w_op_be;
    logic        w_fault;
    logic        w_wr_en;
    logic [AW-1:0] w_idx;
    logic [31:0] w_rd_word;
    logic [31:0] w_merged;
    logic [31:0] w_words [DEPTH];

    assign w_accept = (r_state == S_IDLE) && req_valid;

    // With no wait the access commits on the acceptance edge itself,
    // so the operands come straight from the request inputs.
    assign w_op_write = (r_state == S_IDLE) ? req_write : r_write;
    assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_op_be    = (r_state == S_IDLE) ? req_be    : r_be;

    assign w_idx   = w_op_addr[AW+1:2];
    assign w_fault = (w_op_addr[1:0] != 2'b00) ||
                     ({2'b00, w_op_addr[31:2]} >= 32'(DEPTH));

    assign w_commit = (r_state != S_RESP) && (w_next == S_RESP);
    assign w_wr_en  = w_commit && w_op_write && !w_fault;

    assign w_rd_word = w_words[w_idx];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  req_ready = 1'b1;
            S_WAIT:  req_ready = 1'b0;
            S_RESP:  rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Latency counter: loaded on acceptance, counts down in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture so later input changes cannot disturb the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Response data/error registered at the commit edge, held in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_err   <= w_fault;
            r_rdata <= (w_fault || w_op_write) ? 32'd0 : w_rd_word;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // Byte-lane merge of store data over the current word.
    always_comb begin
        w_merged = w_rd_word;
        for (int b = 0; b < 4; b++) begin
            if (w_op_be[b]) begin
                w_merged[8*b +: 8] = w_op_wdata[8*b +: 8];
            end
        end
    end

    // Storage: one register per word, cleared by reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] r_word;

        // Word update on a committed, non-faulting store to this index.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_word <= 32'd0;
            end else if (w_wr_en && (w_idx == AW'(g))) begin
                r_word <= w_merged;
            end
        end

        assign w_words[g] = r_word;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus, bench-side transaction model
// for the WAIT_CYCLES=2 instance, literal checks for a zero-wait one.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_write, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory image plus "edges since acceptance".
    logic [31:0] m_mem [DEPTH];
    bit          m_busy  = 0;
    bit          m_valid = 0;
    int          m_age   = 0;
    bit          m_w;
    logic [31:0] m_a, m_d;
    logic [3:0]  m_be;
    logic [31:0] m_rd  = 0;
    bit          m_err = 0;

    task automatic m_commit();
        bit f;
        int idx;
        f = (m_a[1:0] != 2'b00) || ((m_a >> 2) >= DEPTH);
        m_err = f;
        m_rd  = 0;
        if (!f) begin
            idx = int'(m_a >> 2);
            if (!m_w) begin
                m_rd = m_mem[idx];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) m_mem[idx][8*b +: 8] = m_d[8*b +: 8];
            end
        end
        m_valid = 1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                foreach (m_mem[i]) m_mem[i] = 0;
                m_busy = 0; m_valid = 0; m_age = 0;
                m_rd = 0; m_err = 0;
            end else if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1; m_age = 0;
                    m_w = req_write; m_a = req_addr;
                    m_d = req_wdata; m_be = req_be;
                    if (m_age >= W) m_commit();
                end
            end else if (!m_valid) begin
                m_age++;
                if (m_age >= W) m_commit();
            end else if (rsp_ready) begin
                m_busy = 0; m_valid = 0;
            end
            #1;
            chk("mdl_req_ready", 32'(req_ready), 32'(!m_busy));
            chk("mdl_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("mdl_rsp_rdata", rsp_rdata, m_rd);
            chk("mdl_rsp_err", 32'(rsp_err), 32'(m_err));
        end
    end

    task automatic do_req(input string nm, input bit w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input bit exp_e);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a;
        req_wdata = d; req_be = be; rsp_ready = 0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_acc_wait"}, 32'(n), 32'd0);
        @(negedge clk);
        req_valid = 0; req_write = ~w;
        req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_err"}, 32'(rsp_err), 32'(exp_e));
        if (hold > 0) begin
            req_valid = 1; req_write = 1; req_addr = 32'h10;
            req_wdata = 32'h5555_5555; req_be = 4'hF;
        end
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d_valid", nm, h), 32'(rsp_valid), 1);
            chk($sformatf("%s_hold%0d_ready", nm, h), 32'(req_ready), 0);
            chk($sformatf("%s_hold%0d_rdata", nm, h), rsp_rdata, exp_rd);
            chk($sformatf("%s_hold%0d_err", nm, h), 32'(rsp_err), 32'(exp_e));
        end
        req_valid = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic set_z(input int k);
        z_req_write = (k < 4);
        z_req_addr  = 32'(4 * (k % 4));
        z_req_wdata = 32'hA0 + 32'(k);
        z_req_be    = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0;
        req_wdata = 0; req_be = 0; rsp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0;
        z_req_wdata = 0; z_req_be = 0; z_rsp_ready = 0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_z_req_ready", 32'(z_req_ready), 1);
        chk("rst_z_rsp_valid", 32'(z_rsp_valid), 0);
        rst = 1;

        do_req("st_full", 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, 0);
        do_req("ld_full", 0, 32'h10, 0, 4'h0, 0, 3, 32'hDEAD_BEEF, 0);
        do_req("st_part", 1, 32'h10, 32'h0000_00AA, 4'b0001, 0, 3, 0, 0);
        do_req("ld_part", 0, 32'h10, 0, 4'hF, 0, 3, 32'hDEAD_BEAA, 0);
        do_req("ld_mis", 0, 32'h3, 0, 4'hF, 0, 3, 0, 1);
        do_req("ld_oor", 0, 32'(4 * DEPTH), 0, 4'hF, 0, 3, 0, 1);
        do_req("st_mis", 1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0, 3, 0, 1);
        do_req("st_be0", 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 0, 3, 0, 0);
        do_req("ld_hold", 0, 32'h10, 0, 4'h0, 5, 3, 32'hDEAD_BEAA, 0);
        do_req("st_b2", 1, 32'h14, 32'h12CC_3456, 4'b0100, 0, 3, 0, 0);
        do_req("ld_b2", 0, 32'h14, 0, 4'h0, 0, 3, 32'h00CC_0000, 0);

        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h20;
        req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(negedge clk);
        req_valid = 0;
        chk("rst_mid_in_wait", 32'(req_ready), 0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mid_req_ready", 32'(req_ready), 1);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 0);
        chk("rst_mid_rsp_err", 32'(rsp_err), 0);
        @(negedge clk);
        rst = 1;
        do_req("ld_rst20", 0, 32'h20, 0, 4'h0, 0, 3, 0, 0);
        do_req("ld_rst10", 0, 32'h10, 0, 4'h0, 0, 3, 0, 0);

        z_rsp_ready = 1;
        @(negedge clk);
        set_z(0);
        z_req_valid = 1;
        for (int i = 1; i <= 16; i++) begin
            int k;
            @(negedge clk);
            k = (i - 1) / 2;
            if (i % 2 == 1) begin
                chk($sformatf("w0_valid_%0d", i), 32'(z_rsp_valid), 1);
                chk($sformatf("w0_ready_%0d", i), 32'(z_req_ready), 0);
                chk($sformatf("w0_err_%0d", i), 32'(z_rsp_err), 0);
                chk($sformatf("w0_rdata_%0d", i), z_rsp_rdata,
                    (k < 4) ? 32'd0 : 32'hA0 + 32'(k - 4));
                if (k < 7) set_z(k + 1);
                else z_req_valid = 0;
            end else begin
                chk($sformatf("w0_valid_%0d", i), 32'(z_rsp_valid), 0);
                chk($sformatf("w0_ready_%0d", i), 32'(z_req_ready), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
